// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit write-only bus driver: power-on init sequence, then byte requests split into two E-strobed nibbles.
// Optional LCD_CTRL_FAST_SIM_EN forces one clock per microsecond for fast simulation.
module lcd_hd44780_ctrl #(
  parameter int unsigned CLK_HZ      = 27_000_000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 12,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned EXEC_US     = 40,
  parameter int unsigned LONG_US     = 1640,
  parameter int unsigned POWER_ON_US = 15000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lcd_data,
  input  logic       lcd_write,
  input  logic       lcd_cmd_data,
  output logic       lcd_busy,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

`ifdef LCD_CTRL_FAST_SIM_EN
  localparam int unsigned CYC_PER_US = 1;
`else
  localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
`endif

  localparam int unsigned FIRST_NIB_US = 4100;
  localparam int unsigned NIB_US       = 100;
  localparam int unsigned MAX_US =
    (POWER_ON_US > LONG_US) ? ((POWER_ON_US > FIRST_NIB_US) ? POWER_ON_US : FIRST_NIB_US)
                            : ((LONG_US > FIRST_NIB_US) ? LONG_US : FIRST_NIB_US);
  localparam int unsigned CNT_W = $clog2(MAX_US * CYC_PER_US + 1) + 1;

  localparam logic [CNT_W-1:0] PWR_LD       = CNT_W'(POWER_ON_US * CYC_PER_US - 1);
  localparam logic [CNT_W-1:0] SETUP_LD     = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD     = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD      = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_CYC     = CNT_W'(EXEC_US * CYC_PER_US);
  localparam logic [CNT_W-1:0] LONG_CYC     = CNT_W'(LONG_US * CYC_PER_US);
  localparam logic [CNT_W-1:0] FIRST_NIB_CY = CNT_W'(FIRST_NIB_US * CYC_PER_US);
  localparam logic [CNT_W-1:0] NIB_CY       = CNT_W'(NIB_US * CYC_PER_US);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);

  localparam logic [3:0] NIB_STEPS  = 4'd4;
  localparam logic [3:0] INIT_STEPS = 4'd8;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_NIB,
    INIT_BYTE,
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    EXEC_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_q;
  logic [3:0]       init_step;
  logic [7:0]       byte_q;
  logic             single_q;
  logic             lo_phase;

  logic [3:0]       init_nib_c;
  logic [CNT_W-1:0] init_nib_wait_c;
  logic [7:0]       init_byte_c;

  // Clear/home commands need the long execution delay, everything else the short one.
  function automatic logic [CNT_W-1:0] byte_wait(input logic is_data, input logic [7:0] b);
    return (!is_data && (b[7:2] == 6'd0)) ? LONG_CYC : EXEC_CYC;
  endfunction

  always_comb begin
    init_nib_c      = (init_step == 4'd3) ? 4'h2 : 4'h3;
    init_nib_wait_c = (init_step == 4'd0) ? FIRST_NIB_CY : NIB_CY;
    case (init_step)
      4'd4:    init_byte_c = 8'h28;
      4'd5:    init_byte_c = 8'h0C;
      4'd6:    init_byte_c = 8'h06;
      default: init_byte_c = 8'h01;
    endcase
  end

  assign lcd_rw = 1'b0;

  // Init waits end one cycle early; the INIT_NIB/INIT_BYTE dispatch cycle completes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWR_WAIT;
      cnt       <= PWR_LD;
      wait_q    <= CNT_ZERO;
      init_step <= 4'd0;
      byte_q    <= 8'h00;
      single_q  <= 1'b0;
      lo_phase  <= 1'b0;
      lcd_busy  <= 1'b1;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_d     <= 4'h0;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (cnt == CNT_ONE) state <= INIT_NIB;
          else                cnt   <= cnt - CNT_ONE;
        end

        INIT_NIB: begin
          lcd_rs    <= 1'b0;
          lcd_d     <= init_nib_c;
          single_q  <= 1'b1;
          lo_phase  <= 1'b0;
          wait_q    <= init_nib_wait_c;
          init_step <= init_step + 4'd1;
          cnt       <= SETUP_LD;
          state     <= SETUP;
        end

        INIT_BYTE: begin
          if (init_step == INIT_STEPS) begin
            init_done <= 1'b1;
            lcd_busy  <= 1'b0;
            state     <= IDLE;
          end else begin
            byte_q    <= init_byte_c;
            lcd_rs    <= 1'b0;
            lcd_d     <= init_byte_c[7:4];
            single_q  <= 1'b0;
            lo_phase  <= 1'b0;
            wait_q    <= byte_wait(1'b0, init_byte_c);
            init_step <= init_step + 4'd1;
            cnt       <= SETUP_LD;
            state     <= SETUP;
          end
        end

        IDLE: begin
          if (lcd_write && !lcd_busy) begin
            byte_q   <= lcd_data;
            lcd_rs   <= lcd_cmd_data;
            lcd_d    <= lcd_data[7:4];
            single_q <= 1'b0;
            lo_phase <= 1'b0;
            wait_q   <= byte_wait(lcd_cmd_data, lcd_data);
            lcd_busy <= 1'b1;
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == CNT_ZERO) begin
            lcd_e <= 1'b1;
            cnt   <= PULSE_LD;
            state <= E_HIGH;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        E_HIGH: begin
          if (cnt == CNT_ZERO) begin
            lcd_e <= 1'b0;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        // After the high nibble of a full byte, go straight into the low nibble.
        HOLD: begin
          if (cnt == CNT_ZERO) begin
            if (!single_q && !lo_phase) begin
              lo_phase <= 1'b1;
              lcd_d    <= byte_q[3:0];
              cnt      <= SETUP_LD;
              state    <= SETUP;
            end else begin
              cnt   <= wait_q - CNT_ONE;
              state <= EXEC_WAIT;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        EXEC_WAIT: begin
          if (init_done) begin
            if (cnt == CNT_ZERO) begin
              lcd_busy <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end else if (cnt == CNT_ONE) begin
            state <= (init_step < NIB_STEPS) ? INIT_NIB : INIT_BYTE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: stimulus pushes expected nibbles and busy lengths, a monitor checks the pins.
module tb_lcd_hd44780_ctrl;
  localparam int SETUP    = 2;
  localparam int PULSE    = 12;
  localparam int HOLD     = 2;
  localparam int EXEC_US  = 40;
  localparam int LONG_US  = 1640;
  localparam int NIB_CYC  = SETUP + PULSE + HOLD;
  localparam int INIT_CYC = 15000 + 4100 + 3 * 100 + 3 * EXEC_US + LONG_US + 4 * NIB_CYC + 8 * NIB_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_write = 1'b0;
  logic       lcd_cmd_data = 1'b0;
  logic       lcd_busy, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_d;

  lcd_hd44780_ctrl #(.CLK_HZ(1_000_000)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_write(lcd_write),
    .lcd_cmd_data(lcd_cmd_data), .lcd_busy(lcd_busy), .init_done(init_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;

  // gap = number of E-low cycles expected before the E rise; 0 means not checked.
  typedef struct {
    logic       rs;
    logic [3:0] d;
    int         gap;
  } nib_t;

  nib_t exp_nib[$];
  int   exp_len[$];
  int   exp_tol[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int req, input int tol);
    checks++;
    if (act > req + tol || act < req - tol) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d(+/-%0d) at %0t", name, act, req, tol, $time);
    end
  endtask

  function automatic int wait_cycles(input logic is_data, input logic [7:0] b);
    return (!is_data && b < 8'd4) ? LONG_US : EXEC_US;
  endfunction

  task automatic push_nib(input logic rs, input logic [3:0] d, input int gap);
    nib_t n;
    n.rs = rs; n.d = d; n.gap = gap;
    exp_nib.push_back(n);
  endtask

  task automatic push_byte(input logic is_data, input logic [7:0] b, input int first_gap, input bit with_len);
    push_nib(is_data, b[7:4], first_gap);
    push_nib(is_data, b[3:0], HOLD + SETUP);
    if (with_len) begin
      exp_len.push_back(2 * NIB_CYC + wait_cycles(is_data, b));
      exp_tol.push_back(0);
    end
  endtask

  task automatic push_init();
    push_nib(1'b0, 4'h3, 0);
    push_nib(1'b0, 4'h3, 0);
    push_nib(1'b0, 4'h3, 0);
    push_nib(1'b0, 4'h2, 0);
    push_byte(1'b0, 8'h28, 0, 1'b0);
    push_byte(1'b0, 8'h0C, 0, 1'b0);
    push_byte(1'b0, 8'h06, 0, 1'b0);
    push_byte(1'b0, 8'h01, 0, 1'b0);
    exp_len.push_back(INIT_CYC);
    exp_tol.push_back(1);
  endtask

  // Monitor: pin-level checks against the scoreboard queues.
  nib_t cur;
  logic e_prev = 1'b0;
  logic busy_prev = 1'b1;
  int   busy_cnt = 0;
  int   e_w = 0;
  int   gap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      e_prev = 1'b0; busy_prev = 1'b1; busy_cnt = 0; e_w = 0; gap = 0;
    end else begin
      if (lcd_busy && !busy_prev) gap = 0;
      if (!lcd_e && e_prev) begin
        check("e_width", e_w, PULSE);
        check("hold_rs", lcd_rs, cur.rs);
        check("hold_d", lcd_d, cur.d);
        gap = 0;
      end
      if (lcd_e && !e_prev) begin
        if (exp_nib.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_e_pulse rs=%0d d=%0h at %0t", lcd_rs, lcd_d, $time);
          cur.rs = lcd_rs; cur.d = lcd_d; cur.gap = 0;
        end else begin
          cur = exp_nib.pop_front();
          check("nib_rs", lcd_rs, cur.rs);
          check("nib_d", lcd_d, cur.d);
          check("rw_low", lcd_rw, 0);
          if (cur.gap != 0) check("setup_gap", gap, cur.gap);
        end
        e_w = 0;
      end
      if (lcd_e) e_w++; else gap++;
      if (lcd_busy) busy_cnt++;
      if (!lcd_busy && busy_prev) begin
        if (exp_len.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_busy_period actual=%0d at %0t", busy_cnt, $time);
        end else begin
          check_tol("busy_len", busy_cnt, exp_len.pop_front(), exp_tol.pop_front());
        end
        check("done_at_idle", init_done, 1);
        busy_cnt = 0;
      end
      e_prev = lcd_e;
      busy_prev = lcd_busy;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (lcd_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (lcd_busy) begin
      checks++; errors++;
      $display("FAIL wait_idle busy still high after %0d cycles", budget);
    end
  endtask

  task automatic send(input logic is_data, input logic [7:0] b, input int idle_gap);
    wait_idle(5000);
    repeat (idle_gap) @(negedge clk);
    push_byte(is_data, b, SETUP, 1'b1);
    lcd_data = b; lcd_cmd_data = is_data; lcd_write = 1'b1;
    @(posedge clk);
    #1 lcd_write = 1'b0;
    @(negedge clk);
    check("accept_busy", lcd_busy, 1);
    check("accept_rs", lcd_rs, is_data);
    check("accept_d", lcd_d, b[7:4]);
  endtask

  task automatic check_reset_pins();
    check("rst_busy", lcd_busy, 1);
    check("rst_done", init_done, 0);
    check("rst_e", lcd_e, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_d", lcd_d, 0);
    check("rst_rw", lcd_rw, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       dat;
    int         n;

    repeat (3) @(negedge clk);
    check_reset_pins();
    push_init();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle(30000);
    check("init_done", init_done, 1);

    send(1'b1, 8'h41, 0);
    send(1'b0, 8'h01, 0);
    send(1'b0, 8'h02, 1);

    // Second request lands mid-transfer and must be dropped.
    send(1'b1, 8'h41, 0);
    repeat (20) @(negedge clk);
    lcd_data = 8'h42; lcd_cmd_data = 1'b1; lcd_write = 1'b1;
    @(posedge clk);
    #1 lcd_write = 1'b0;

    // Held request: accepts at edge offsets 0, 73 and 146 only.
    wait_idle(5000);
    for (int i = 0; i < 3; i++) push_byte(1'b1, 8'h48, SETUP, 1'b1);
    lcd_data = 8'h48; lcd_cmd_data = 1'b1; lcd_write = 1'b1;
    repeat (2 * (2 * NIB_CYC + EXEC_US + 1) + 1) @(posedge clk);
    #1 lcd_write = 1'b0;

    for (int i = 0; i < 25; i++) begin
      dat = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      if (i % 9 == 4) begin
        dat = 1'b0;
        b = 8'($urandom_range(0, 3));
      end
      send(dat, b, int'($urandom_range(0, 3)));
    end

    // Reset while E is high.
    send(1'b1, 8'h55, 0);
    n = 0;
    while (!lcd_e && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("e_reached", lcd_e, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_pins();
    exp_nib.delete(); exp_len.delete(); exp_tol.delete();
    push_init();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", init_done, 0);
    wait_idle(30000);
    check("reinit_done", init_done, 1);
    send(1'b1, 8'h7E, 0);

    wait_idle(5000);
    repeat (5) @(negedge clk);
    check("exp_nib_left", exp_nib.size(), 0);
    check("exp_len_left", exp_len.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_hd44780_ctrl.md
# lcd_hd44780_ctrl

- Low-level HD44780 character-LCD bus driver for a 4-bit, write-only physical interface.
- Accepts byte requests (command or data) over the `lcd_data`/`lcd_write`/`lcd_cmd_data`/`lcd_busy` handshake that the text-display layer issues.
- Runs the power-on init sequence itself, then serializes each byte into two E-strobed nibbles followed by the controller's execution delay.
- Sits between the text-display logic and the LCD pins.

## Interface
- `CLK_HZ`, 27_000_000: clock frequency; `CYC_PER_US = CLK_HZ/1_000_000`.
- `SETUP_CYC`, 2: cycles RS/D stable before E rises.
- `PULSE_CYC`, 12: E-high cycles.
- `HOLD_CYC`, 2: cycles RS/D held after E falls.
- `EXEC_US`, 40: post-byte wait for normal commands/data.
- `LONG_US`, 1640: post-byte wait for clear/home.
- `POWER_ON_US`, 15000: wait after reset before the first init nibble.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `lcd_data`  in  8  byte to send.
- `lcd_write`  in  1  request strobe; accepted when high and `lcd_busy` low.
- `lcd_cmd_data`  in  1  0 = command (RS=0), 1 = data (RS=1).
- `lcd_busy`  out  1  high while initializing or executing an accepted byte.
- `init_done`  out  1  sticky high once init completes.
- `lcd_rs`  out  1  LCD register select.
- `lcd_rw`  out  1  tied 0 (write-only).
- `lcd_e`  out  1  LCD enable strobe.
- `lcd_d`  out  4  LCD data bus D7..D4.

## Operation
- States: `PWR_WAIT`, `INIT_NIB`, `INIT_BYTE`, `IDLE`, `SETUP`, `E_HIGH`, `HOLD`, `EXEC_WAIT`.
- `PWR_WAIT`: count `POWER_ON_US` µs, then go to `INIT_NIB`.
- `INIT_NIB`: send single high nibbles with RS=0:
  - 0x3, wait 4100 µs
  - 0x3, wait 100 µs
  - 0x3, wait 100 µs
  - 0x2, wait 100 µs
- `INIT_BYTE`: send full bytes with RS=0:
  - 0x28, wait `EXEC_US`
  - 0x0C, wait `EXEC_US`
  - 0x06, wait `EXEC_US`
  - 0x01, wait `LONG_US`
- After the last init wait: `init_done`=1, `lcd_busy`=0, go to `IDLE`.
- `IDLE`: when `lcd_write` && !`lcd_busy`, latch `lcd_data` and `lcd_cmd_data`, then go to `SETUP`.
- Byte transfer:
  - High nibble first: `SETUP` → `E_HIGH` → `HOLD`.
  - Then low nibble: same three states.
  - Then `EXEC_WAIT`.
  - Single-nibble init transfers skip the low nibble.
- Wait selection: `LONG_US` if command && `byte[7:2]==0` (clear 0x01, home 0x02/0x03); otherwise `EXEC_US`.
- One down-counter serves all delays; width sized for `POWER_ON_US*CYC_PER_US` (≥20 bits at defaults).
- `lcd_write` pulses while busy are ignored and not queued.
- `lcd_rw` is 0 at all times.

## Timing
- Reset values:
  - `lcd_busy`=1, `init_done`=0.
  - `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_d`=0.
- All outputs are registered.
- Reset asserted mid-operation: outputs return immediately to reset values; init restarts from `PWR_WAIT` on release.
- Accept: `lcd_write` sampled high with `lcd_busy`=0 at edge N. `lcd_busy`=1 from the cycle after edge N, so the requester's next-cycle check sees busy.
- Pin timing during a nibble:
  - RS and nibble appear in the same cycle busy rises.
  - `lcd_e` rises after `SETUP_CYC` cycles and stays high `PULSE_CYC` cycles.
  - RS and D are held `HOLD_CYC` cycles after E falls.
  - The low nibble follows immediately.
- Busy duration for a byte is exactly `2*(SETUP_CYC+PULSE_CYC+HOLD_CYC) + wait_us*CYC_PER_US` cycles. The next request is accepted on the first cycle busy is low.
- `lcd_d` and `lcd_rs` keep their last driven values while idle; `lcd_e` stays 0.

## Configuration
- `LCD_CTRL_FAST_SIM_EN`:
  - Defined: `CYC_PER_US` is forced to 1, so every µs delay counts clock cycles. `SETUP_CYC`/`PULSE_CYC`/`HOLD_CYC` are unchanged.
  - Undefined: `CYC_PER_US = CLK_HZ/1_000_000`.

## Test plan
All scenarios use `LCD_CTRL_FAST_SIM_EN` defined and default parameters.

- **Power-on.** Release reset, no requests.
  - `lcd_e` pulses 12 times: nibbles 3, 3, 3, 2, 2, 8, 0, C, 0, 6, 0, 1, all with RS=0.
  - `init_done` and `lcd_busy`↓ occur together, 15000+4100+300+120+1640+ (4·16+8·16) cycles after reset release, ±1.
- **Data byte.** After init, `lcd_write`=1 for 1 cycle with `lcd_data`=0x41, `lcd_cmd_data`=1.
  - Busy rises the next cycle.
  - RS=1; D=4 then D=1 on successive E pulses, each E pulse 12 cycles wide.
  - Busy is high exactly 72 cycles.
- **Clear command.** `lcd_data`=0x01, `lcd_cmd_data`=0.
  - RS=0; busy is high exactly 32+1640 cycles.
- **Write while busy.** Pulse a second `lcd_write` (0x42) in the middle of a transfer of 0x41.
  - No extra E pulses; only 0x41 appears on the bus.
- **Back-to-back.** Hold `lcd_write` high continuously with 0x48.
  - A new transfer starts on the first cycle busy is low; E pulse count is 2 per byte.
- **Mid-transfer reset.** Assert `rst_n` during `E_HIGH`.
  - `lcd_e`=0, `lcd_busy`=1 and `init_done`=0 immediately.
  - On release, the power-on sequence repeats from the 15000-cycle wait.
